// File: rtl/inst_fetch_master.sv
// Instruction-fetch bus initiator: one fetch at a time over ce/addr/inst/ack, with flush,
// misaligned-address and bus-timeout handling. Optional one-entry last-hit tag: IF_LASTHIT_EN.
module inst_fetch_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_valid_o,
  output logic              cpu_err_o,
  output logic              stall_req_o,
  output logic              bus_ce_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic [DATA_W-1:0] bus_inst_i,
  input  logic              bus_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_TO_LAST =
    CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_inst, w_inst_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic              w_accept;
  logic              w_aligned;
  logic              w_timeout;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_inst;

  assign cpu_ready_o = !flush_i && ((r_state == S_IDLE) || ((r_state == S_WAIT) && bus_ack_i));
  assign w_accept    = cpu_req_i && cpu_ready_o;
  assign w_aligned   = (cpu_addr_i[1:0] == 2'b00);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_TO_LAST);

  assign cpu_inst_o  = r_inst;
  assign cpu_valid_o = r_valid;
  assign cpu_err_o   = r_err;
  assign bus_ce_o    = r_ce;
  assign bus_addr_o  = r_addr;
  assign stall_req_o = (r_state == S_WAIT);

`ifdef IF_LASTHIT_EN
  logic [ADDR_W-1:0] r_tag_addr;
  logic [DATA_W-1:0] r_tag_inst;
  logic              r_tag_vld;
  logic              w_fill;
  logic              w_tag_clr;

  assign w_fill     = (r_state == S_WAIT) && !flush_i && bus_ack_i;
  assign w_tag_clr  = (r_state == S_WAIT) && !flush_i && !bus_ack_i && w_timeout;
  assign w_hit      = r_tag_vld && (r_tag_addr == cpu_addr_i);
  assign w_hit_inst = r_tag_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_addr <= '0;
      r_tag_inst <= '0;
      r_tag_vld  <= 1'b0;
    end else if (w_tag_clr) begin
      r_tag_vld  <= 1'b0;
    end else if (w_fill) begin
      r_tag_addr <= r_addr;
      r_tag_inst <= bus_inst_i;
      r_tag_vld  <= 1'b1;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = r_ce;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_inst_nxt  = r_inst;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_aligned) begin
            w_state_nxt = S_ERR;
          end else if (w_hit) begin
            w_inst_nxt  = w_hit_inst;
            w_valid_nxt = 1'b1;
          end else begin
            w_addr_nxt  = cpu_addr_i;
            w_ce_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          w_ce_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (bus_ack_i) begin
          w_inst_nxt  = bus_inst_i;
          w_valid_nxt = 1'b1;
          // A reload in the ack cycle always goes to the bus: a tag hit here would need a
          // second valid pulse in the same cycle as the one being returned.
          if (w_accept && w_aligned) begin
            w_addr_nxt = cpu_addr_i;
            w_cnt_nxt  = '0;
          end else if (w_accept) begin
            w_ce_nxt    = 1'b0;
            w_state_nxt = S_ERR;
          end else begin
            w_ce_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_ce_nxt    = 1'b0;
          w_inst_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ERR: begin
        w_ce_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
        if (!flush_i) begin
          w_inst_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_ce_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ce    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_inst  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= w_ce_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_addr  <= w_addr_nxt;
      r_inst  <= w_inst_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_master.sv
// Scoreboard bench for inst_fetch_master: randomized fetches against a transaction-level model;
// a monitor thread pops expected (cycle, inst, err) responses on every cpu_valid_o pulse.
module tb_inst_fetch_master;

  localparam int TO = 16;
`ifdef IF_LASTHIT_EN
  localparam bit LH = 1'b1;
`else
  localparam bit LH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_ready_o;
  logic        flush_i;
  logic [31:0] cpu_inst_o;
  logic        cpu_valid_o;
  logic        cpu_err_o;
  logic        stall_req_o;
  logic        bus_ce_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_inst_i;
  logic        bus_ack_i;

  inst_fetch_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_ready_o(cpu_ready_o), .flush_i(flush_i), .cpu_inst_o(cpu_inst_o),
    .cpu_valid_o(cpu_valid_o), .cpu_err_o(cpu_err_o), .stall_req_o(stall_req_o),
    .bus_ce_o(bus_ce_o), .bus_addr_o(bus_addr_o), .bus_inst_i(bus_inst_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: ack after ack_delay extra WAIT cycles (0 = combinational from bus_ce_o).
  int   ack_delay = 0;
  logic ack_en    = 1'b1;
  int   ce_cnt    = 0;
  always @(posedge clk) begin
    if (!bus_ce_o || bus_ack_i) ce_cnt <= 0;
    else                        ce_cnt <= ce_cnt + 1;
  end

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h10) return 32'h1111_1111;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus_ack_i  = bus_ce_o && ack_en && (ce_cnt >= ack_delay);
  assign bus_inst_i = bus_ce_o ? rom(bus_addr_o) : 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] tag_addr = 32'h0;
  logic [31:0] tag_inst = 32'h0;
  bit          tag_vld  = 1'b0;
  int          prev_done = -1;
  logic [31:0] exp_bus_addr = 32'h0;

  task automatic push(input int c, input logic [31:0] i, input logic e);
    exp_t x;
    x.cyc = c; x.inst = i; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ce_matches_stall", 32'(bus_ce_o), 32'(stall_req_o));
        if (bus_ce_o) chk("bus_addr", bus_addr_o, exp_bus_addr);
        if (cpu_valid_o) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid cyc %0d got inst %h err %b want no pulse",
                     cyc, cpu_inst_o, cpu_err_o);
          end else begin
            e = sbq.pop_front();
            if (cyc != e.cyc || cpu_inst_o !== e.inst || cpu_err_o !== e.err) begin
              errors++;
              $display("FAIL response got cyc %0d inst %h err %b want cyc %0d inst %h err %b",
                       cyc, cpu_inst_o, cpu_err_o, e.cyc, e.inst, e.err);
            end
          end
        end
      end
    end
  endtask

  task automatic gap(input int n);
    cpu_req_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request; fj>0 pulses flush_i in the fj-th cycle after acceptance.
  task automatic do_txn(input logic [31:0] addr, input int fj);
    bit got;
    bit aligned;
    bit hit;
    int a;
    cpu_addr_i = addr;
    cpu_req_i  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr %h got ready 0 want ready 1", addr);
      cpu_req_i = 1'b0;
      return;
    end
    a = cyc + 1;
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    aligned = (addr[1:0] == 2'b00);
    hit = LH && aligned && tag_vld && (tag_addr == addr) && (a != prev_done);
    if (!aligned) begin
      if (fj != 1) push(a + 1, 32'h0, 1'b1);
    end else if (hit) begin
      push(a, tag_inst, 1'b0);
      prev_done = -1;
    end else begin
      exp_bus_addr = addr;
      if (!ack_en) begin
        if (fj == 0) begin
          push(a + TO, 32'h0, 1'b1);
          tag_vld = 1'b0;
        end
      end else if (fj == 0) begin
        push(a + 1 + ack_delay, rom(addr), 1'b0);
        tag_addr  = addr;
        tag_inst  = rom(addr);
        tag_vld   = 1'b1;
        prev_done = a + 1 + ack_delay;
      end
    end
    if (fj > 0) begin
      repeat (fj - 1) begin
        @(posedge clk);
        #1;
      end
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      chk("flush_ce", 32'(bus_ce_o), 32'h0);
      chk("flush_stall", 32'(stall_req_o), 32'h0);
    end
  endtask

  initial begin
    int          d_list[3] = '{0, 1, 3};
    int unsigned r;
    bit          mis;
    int          fj;
    logic [31:0] addr;
    bit          got;

    rst        = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_addr_i = 32'h0;
    flush_i    = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", 32'(bus_ce_o), 32'h0);
    chk("rst_valid", 32'(cpu_valid_o), 32'h0);
    chk("rst_err", 32'(cpu_err_o), 32'h0);
    chk("rst_inst", cpu_inst_o, 32'h0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_stall", 32'(stall_req_o), 32'h0);
    rst = 1'b0;
    chk("idle_ready", 32'(cpu_ready_o), 32'h1);

    // Single fetch, then back-to-back with combinational ack
    do_txn(32'h10, 0);
    gap(2);
    do_txn(32'h0, 0);
    do_txn(32'h4, 0);
    do_txn(32'h8, 0);
    gap(3);

    // Flush in the 2nd WAIT cycle of a slow fetch, then a fresh fetch
    ack_delay = 2;
    do_txn(32'h30, 2);
    do_txn(32'h34, 0);
    gap(20);

    // Timeouts (one flushed before expiry)
    ack_en = 1'b0;
    do_txn(32'h40, 0);
    do_txn(32'h44, 5);
    gap(20);
    ack_en = 1'b1;
    ack_delay = 0;

    // Misaligned, with and without flush in ERR
    do_txn(32'h6, 0);
    gap(1);
    do_txn(32'h7, 1);
    do_txn(32'h48, 0);
    gap(3);

    // Reset in the middle of a fetch
    ack_delay = 3;
    cpu_addr_i = 32'h50;
    cpu_req_i  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst_accept", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    exp_bus_addr = 32'h50;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tag_vld = 1'b0;
    prev_done = -1;
    chk("midrst_ce", 32'(bus_ce_o), 32'h0);
    chk("midrst_stall", 32'(stall_req_o), 32'h0);
    chk("midrst_valid", 32'(cpu_valid_o), 32'h0);
    gap(8);

`ifdef IF_LASTHIT_EN
    ack_delay = 0;
    do_txn(32'h20, 0);
    gap(2);
    do_txn(32'h20, 0);
    gap(2);
    ack_en = 1'b0;
    do_txn(32'h60, 0);
    gap(20);
    ack_en = 1'b1;
    do_txn(32'h20, 0);
    gap(3);
`endif

    // Randomized phases per ROM latency
    foreach (d_list[k]) begin
      gap(20);
      ack_delay = d_list[k];
      for (int n = 0; n < 50; n++) begin
        r    = $urandom_range(0, 15);
        mis  = ($urandom_range(0, 7) == 0);
        addr = 32'(r * 4) + (mis ? 32'($urandom_range(1, 3)) : 32'h0);
        fj   = 0;
        if ($urandom_range(0, 7) == 0) fj = mis ? 1 : int'($urandom_range(1, d_list[k] + 1));
        do_txn(addr, fj);
        r = $urandom_range(0, 2);
        if (r != 0) gap(int'(r));
      end
    end

    gap(40);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got %0d outstanding want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
